// File: rtl/debug_cmd_arbiter.sv
// Two-requester debug command arbiter: round-robin command grant, one-shot issue
// to the debug port, response forwarding with length cap, timeout and guard cycle.
module debug_cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RESP_LEN   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req0_cmd_i,
  input  logic       req0_cmd_valid_i,
  output logic       req0_cmd_ready_o,
  output logic [7:0] req0_resp_o,
  output logic       req0_resp_valid_o,
  output logic       req0_resp_last_o,
  input  logic [7:0] req1_cmd_i,
  input  logic       req1_cmd_valid_i,
  output logic       req1_cmd_ready_o,
  output logic [7:0] req1_resp_o,
  output logic       req1_resp_valid_o,
  output logic       req1_resp_last_o,
  output logic [7:0] dbg_cmd_o,
  output logic       dbg_cmd_valid_o,
  input  logic [7:0] dbg_resp_i,
  input  logic       dbg_resp_valid_i,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic [7:0] timeout_count_o
);
  localparam int CW = $clog2(MAX_RESP_LEN + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, STREAM, FLUSH, TO_RESP, GUARD} state_e;

  state_e          state_q;
  logic            prio_q;        // requester that wins a tie (the one not served last)
  logic [1:0]      grant_q;
  logic [7:0]      dbg_cmd_q;
  logic            dbg_cmd_valid_q;
  logic [7:0]      hold_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      tcnt_q;
  logic [7:0]      resp_q;
  logic [1:0]      rvld_q;
  logic [1:0]      rlast_q;
  logic [7:0]      tocnt_q;

  logic [1:0] req_vld;
  logic [1:0] ready;
  logic       sel;
  logic [7:0] sel_cmd;

  assign req_vld = {req1_cmd_valid_i, req0_cmd_valid_i};

  always_comb begin
    sel = prio_q;
    if (!req_vld[prio_q]) sel = ~prio_q;
    ready = 2'b00;
    if (state_q == IDLE) ready[sel] = req_vld[sel];
    sel_cmd = sel ? req1_cmd_i : req0_cmd_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      prio_q          <= 1'b0;
      grant_q         <= 2'b00;
      dbg_cmd_q       <= 8'h00;
      dbg_cmd_valid_q <= 1'b0;
      hold_q          <= 8'h00;
      cnt_q           <= '0;
      tcnt_q          <= 8'h00;
      resp_q          <= 8'h00;
      rvld_q          <= 2'b00;
      rlast_q         <= 2'b00;
      tocnt_q         <= 8'h00;
    end else begin
      dbg_cmd_valid_q <= 1'b0;
      rvld_q          <= 2'b00;
      rlast_q         <= 2'b00;
      case (state_q)
        IDLE: if (|ready) begin
          dbg_cmd_q       <= sel_cmd;
          dbg_cmd_valid_q <= 1'b1;
          grant_q         <= sel ? 2'b10 : 2'b01;
          prio_q          <= ~sel;
          state_q         <= ISSUE;
        end
        ISSUE: begin
          tcnt_q  <= 8'h00;
          state_q <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (dbg_resp_valid_i) begin
            hold_q <= dbg_resp_i;
            cnt_q  <= CW'(1);
            if (MAX_RESP_LEN == 1) state_q <= FLUSH;
            else                   state_q <= STREAM;
          end else if (tcnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            state_q <= TO_RESP;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        STREAM: begin
          // Held byte goes out as the next one arrives, so the final byte is known to be last.
          if (dbg_resp_valid_i) begin
            resp_q <= hold_q;
            rvld_q <= grant_q;
            hold_q <= dbg_resp_i;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(MAX_RESP_LEN - 1)) state_q <= FLUSH;
          end else begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          resp_q  <= hold_q;
          rvld_q  <= grant_q;
          rlast_q <= grant_q;
          state_q <= GUARD;
        end
        TO_RESP: begin
          resp_q  <= 8'hFE;
          rvld_q  <= grant_q;
          rlast_q <= grant_q;
          if (tocnt_q != 8'hFF) tocnt_q <= tocnt_q + 8'd1;
          state_q <= GUARD;
        end
        GUARD: begin
          grant_q <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_cmd_ready_o  = ready[0];
  assign req1_cmd_ready_o  = ready[1];
  assign req0_resp_o       = resp_q;
  assign req1_resp_o       = resp_q;
  assign req0_resp_valid_o = rvld_q[0];
  assign req1_resp_valid_o = rvld_q[1];
  assign req0_resp_last_o  = rlast_q[0];
  assign req1_resp_last_o  = rlast_q[1];
  assign dbg_cmd_o         = dbg_cmd_q;
  assign dbg_cmd_valid_o   = dbg_cmd_valid_q;
  assign grant_o           = grant_q;
  assign busy_o            = (state_q != IDLE);
  assign timeout_count_o   = tocnt_q;
endmodule

// File: tb/tb_debug_cmd_arbiter.sv
// Directed bench for debug_cmd_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_debug_cmd_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] c0 = 8'h00, c1 = 8'h00, dr = 8'h00;
  logic       v0 = 1'b0, v1 = 1'b0, dv = 1'b0;
  logic       rdy0, rdy1, r0v, r1v, r0l, r1l, dcv, busy;
  logic [7:0] r0, r1, dcmd, tc;
  logic [1:0] grant;

  always #5 clk = ~clk;

  debug_cmd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_cmd_i(c0), .req0_cmd_valid_i(v0), .req0_cmd_ready_o(rdy0),
    .req0_resp_o(r0), .req0_resp_valid_o(r0v), .req0_resp_last_o(r0l),
    .req1_cmd_i(c1), .req1_cmd_valid_i(v1), .req1_cmd_ready_o(rdy1),
    .req1_resp_o(r1), .req1_resp_valid_o(r1v), .req1_resp_last_o(r1l),
    .dbg_cmd_o(dcmd), .dbg_cmd_valid_o(dcv),
    .dbg_resp_i(dr), .dbg_resp_valid_i(dv),
    .grant_o(grant), .busy_o(busy), .timeout_count_o(tc)
  );

  int tests = 0, fails = 0, ncmd = 0, n0 = 0, nl = 0;
  logic [7:0] q0[$], q1[$];
  logic       l0[$], l1[$];
  logic [7:0] mb[0:31];

  always @(negedge clk) begin
    if (r0v) begin q0.push_back(r0); l0.push_back(r0l); end
    if (r1v) begin q1.push_back(r1); l1.push_back(r1l); end
    if (dcv) ncmd++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick; @(negedge clk); endtask

  task automatic clear_q;
    q0.delete(); q1.delete(); l0.delete(); l1.delete();
  endtask

  task automatic send(input int r, input logic [7:0] c);
    bit got = 1'b0;
    if (r == 0) begin c0 = c; v0 = 1'b1; end else begin c1 = c; v1 = 1'b1; end
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      got = (r == 0) ? rdy0 : rdy1;
      if (!got) tick;
    end
    chk("send_ready", 32'(got), 1);
    tick;
    if (r == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_cmd;
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (dcv) got = 1'b1;
      else tick;
    end
    chk("wait_cmd", 32'(got), 1);
  endtask

  // Debug-side model: returns mb[0..n-1] as a contiguous burst after the command strobe.
  task automatic serve(input int n);
    wait_cmd();
    tick;
    for (int i = 0; i < n; i++) begin dr = mb[i]; dv = 1'b1; tick; end
    dv = 1'b0; dr = 8'h00;
  endtask

  task automatic chk_q0(input string tag, input int n);
    chk($sformatf("%s_len", tag), q0.size(), n);
    for (int i = 0; i < n && i < q0.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), q0[i], mb[i]);
      chk($sformatf("%s_l%0d", tag, i), 32'(l0[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    repeat (2) tick;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_dcmd", dcmd, 8'h00);
    chk("rst_dcv", dcv, 0);
    chk("rst_rv", {r0v, r1v, r0l, r1l}, 4'b0000);
    chk("rst_tc", tc, 8'h00);

    // Single command, 4-byte reply, handshake in first cycle after release
    rst_n = 1'b1;
    mb[0] = 8'h01; mb[1] = 8'h0A; mb[2] = 8'h02; mb[3] = 8'h00;
    n0 = ncmd;
    send(0, 8'h01);
    chk("t037_grant", grant, 2'b01);
    chk("t037_busy", busy, 1);
    chk("t037_dcmd", dcmd, 8'h01);
    chk("t037_dcv", dcv, 1);
    serve(4);
    tick; chk("t037_gap", r0v, 0);
    tick;
    chk("t037_last_v", {r0v, r0l}, 2'b11);
    chk("t037_last_d", r0, 8'h00);
    chk("t037_grant_guard", grant, 2'b01);
    tick;
    chk("t037_idle_busy", busy, 0);
    chk("t037_idle_grant", grant, 2'b00);
    chk("t037_ncmd", ncmd - n0, 1);
    chk_q0("t037", 4);
    chk("t037_q1", q1.size(), 0);

    // Tie after serving req0 favours req1; dropped valids issue nothing
    clear_q;
    c0 = 8'h11; c1 = 8'h22; v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("rr_tie_rdy", {rdy1, rdy0}, 2'b10);
    v0 = 1'b0; v1 = 1'b0;
    n0 = ncmd;
    tick; tick;
    chk("drop_busy", busy, 0);
    chk("drop_ncmd", ncmd - n0, 0);

    // Simultaneous requests after reset: req0 then req1
    rst_n = 1'b0; tick; rst_n = 1'b1;
    clear_q;
    c0 = 8'h03; c1 = 8'hF0; v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("t038_rdy", {rdy1, rdy0}, 2'b01);
    tick;
    v0 = 1'b0;
    chk("t038_grant0", grant, 2'b01);
    chk("t038_dcmd0", dcmd, 8'h03);
    chk("t038_no_rdy_busy", rdy1, 0);
    mb[0] = 8'hAA;
    serve(1);
    wait_cmd();
    chk("t038_grant1", grant, 2'b10);
    chk("t038_dcmd1", dcmd, 8'hF0);
    v1 = 1'b0;
    mb[0] = 8'hBB; mb[1] = 8'hCC;
    serve(2);
    repeat (4) tick;
    chk("t038_q0_len", q0.size(), 1);
    chk("t038_q0_b0", q0[0], 8'hAA);
    chk("t038_q1_len", q1.size(), 2);
    chk("t038_q1_b0", q1[0], 8'hBB);
    chk("t038_q1_b1", q1[1], 8'hCC);
    chk("t038_q1_l", {l1[0], l1[1]}, 2'b01);

    // Timeout: silent debug side
    clear_q;
    send(0, 8'h06);
    chk("t039_dcv", dcv, 1);
    repeat (17) tick;
    chk("t039_pre_v", r0v, 0);
    chk("t039_pre_tc", tc, 8'h00);
    chk("t039_pre_busy", busy, 1);
    tick;
    chk("t039_v", {r0v, r0l}, 2'b11);
    chk("t039_d", r0, 8'hFE);
    chk("t039_tc", tc, 8'h01);
    tick; tick;
    chk("t039_idle", busy, 0);

    // Length cap: 20 bytes offered, 16 forwarded
    clear_q;
    for (int i = 0; i < 20; i++) mb[i] = 8'h10 + 8'(i);
    n0 = ncmd;
    send(0, 8'h09);
    serve(20);
    repeat (6) tick;
    chk("t040_busy", busy, 0);
    chk("t040_ncmd", ncmd - n0, 1);
    chk_q0("t040", 16);

    // Reset in the middle of a response
    clear_q;
    for (int i = 0; i < 5; i++) mb[i] = 8'h31 + 8'(i);
    send(0, 8'h0B);
    wait_cmd();
    tick;
    for (int i = 0; i < 3; i++) begin dr = mb[i]; dv = 1'b1; tick; end
    #2 rst_n = 1'b0;
    #1;
    chk("t041_grant", grant, 2'b00);
    chk("t041_busy", busy, 0);
    chk("t041_dcmd", {dcmd, dcv}, 9'h000);
    chk("t041_resp", {r0, r0v, r0l}, 10'h000);
    chk("t041_tc", tc, 8'h00);
    dv = 1'b0; dr = 8'h00;
    tick; rst_n = 1'b1;
    repeat (4) tick;
    chk("t041_partial", q0.size(), 2);
    nl = 0;
    foreach (l0[i]) nl += int'(l0[i]);
    chk("t041_no_last", nl, 0);
    clear_q;
    mb[0] = 8'h55;
    send(0, 8'h07);
    serve(1);
    repeat (4) tick;
    chk_q0("t041_next", 1);

    // Saturating timeout counter
    for (int k = 0; k < 256; k++) begin
      send(0, 8'h06);
      repeat (19) tick;
      if (k == 253) chk("t042_tc254", tc, 8'hFE);
      if (k == 254) chk("t042_tc255", tc, 8'hFF);
      if (k == 255) chk("t042_tc256", tc, 8'hFF);
    end

    // Continuous requests alternate 0,1,0,1
    rst_n = 1'b0; tick; rst_n = 1'b1;
    c0 = 8'hA0; c1 = 8'hB1; v0 = 1'b1; v1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_cmd();
      chk($sformatf("t033_grant%0d", k), grant, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k == 3) begin v0 = 1'b0; v1 = 1'b0; end
      mb[0] = 8'(k);
      serve(1);
    end
    repeat (5) tick;
    chk("t033_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/debug_cmd_arbiter.md
DEBUG_CMD_ARBITER -- requirements
Module: debug_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max cycles in WAIT_RESP before timeout (range 2..255).
REQ-002 Parameter MAX_RESP_LEN, default 16, max response bytes forwarded per command.
REQ-003 clk  in  1  system clock; all logic on posedge clk.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req0_cmd / req1_cmd  in  8  command byte from requester 0 (UART bridge) / 1 (USB control EP).
REQ-006 req0_cmd_valid / req1_cmd_valid  in  1  command byte valid; held until accepted.
REQ-007 req0_cmd_ready / req1_cmd_ready  out  1  combinational accept strobe; handshake = valid & ready.
REQ-008 req0_resp / req1_resp  out  8  response byte to requester.
REQ-009 req0_resp_valid / req1_resp_valid  out  1  response byte valid, one cycle per byte.
REQ-010 req0_resp_last / req1_resp_last  out  1  marks final byte of response; qualified by resp_valid.
REQ-011 dbg_cmd  out  8  command to debug interface.
REQ-012 dbg_cmd_valid  out  1  one-cycle command strobe to debug interface.
REQ-013 dbg_resp  in  8  response byte from debug interface.
REQ-014 dbg_resp_valid  in  1  response byte valid; bytes arrive contiguous, end = valid low.
REQ-015 grant  out  2  one-hot owner of current transaction; 2'b00 when idle.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 timeout_count  out  8  saturating count of timed-out transactions.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT_RESP, STREAM, FLUSH, TO_RESP, GUARD.
REQ-019 IDLE: ready asserted only to the selected requester; round-robin, the requester not served last wins a tie; after reset requester 0 has priority.
REQ-020 IDLE handshake: latch cmd byte, set grant, go ISSUE; no ready outside IDLE.
REQ-021 ISSUE: dbg_cmd = latched byte, dbg_cmd_valid = 1 for exactly one cycle, go WAIT_RESP, clear timeout counter.
REQ-022 WAIT_RESP: dbg_resp_valid -> capture byte into hold register, byte count = 1, go STREAM; else counter increments; counter reaching TIMEOUT_CYCLES -> TO_RESP.
REQ-023 STREAM, dbg_resp_valid high: emit held byte to granted requester (valid=1, last=0), capture new byte, byte count +1.
REQ-024 STREAM, dbg_resp_valid low: go FLUSH.
REQ-025 FLUSH: emit held byte with valid=1, last=1, go GUARD.
REQ-026 Byte count reaching MAX_RESP_LEN in STREAM: go FLUSH immediately; further dbg_resp bytes dropped until GUARD ends.
REQ-027 Forwarding latency: byte N from dbg_resp appears on reqX_resp 1 cycle after byte N+1 arrives, or 1 cycle after valid drops for the last byte (net 2 cycles for last byte).
REQ-028 TO_RESP: emit single byte 8'hFE, valid=1, last=1, timeout_count +1 saturating at 8'hFF, go GUARD.
REQ-029 GUARD: one cycle, grant cleared, dbg_resp_valid ignored, then IDLE.
REQ-030 Non-granted requester resp_valid/resp_last always 0; resp data bus may be shared.
REQ-031 dbg_resp_valid in IDLE, ISSUE or GUARD ignored, no state change.
REQ-032 Requester dropping cmd_valid before handshake: no grant, no command issued.
REQ-033 Both requesters valid continuously: grants alternate 0,1,0,1.

Reset
REQ-034 rst_n low, any state: state IDLE, grant 0, busy 0, dbg_cmd 0, dbg_cmd_valid 0, all resp/valid/last 0, timeout_count 0, counters 0, round-robin pointer to requester 0.
REQ-035 Reset mid-transaction: partial response discarded; no last byte emitted after release.
REQ-036 First handshake possible in the first cycle after rst_n deasserts.

Verification
REQ-037 req0 sends 8'h01, model returns 01,0A,02,00 -> req0 gets 4 bytes, last on 00, dbg_cmd_valid high exactly 1 cycle.
REQ-038 Both valid same cycle after reset (req0 8'h03, req1 8'hF0) -> req0 served first, then req1; grant 01 then 10.
REQ-039 Model silent after 8'h06 -> TIMEOUT_CYCLES=16 cycles later req gets single 8'hFE with last, timeout_count = 1.
REQ-040 Model streams 20 bytes -> exactly 16 forwarded, last on 16th, FSM back to IDLE.
REQ-041 rst_n pulsed during STREAM of 5-byte response -> all outputs 0, no last emitted, next command served normally.
REQ-042 256 forced timeouts -> timeout_count saturates at 8'hFF.
